// File: rtl/sevseg_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Latency: n/a (types, constants and an elaboration-time legality helper).
// Backpressure: n/a.
package sevseg_pkg;

  // Segments a..g; index 1 is segment a, index 7 is segment g, active-low.
  typedef logic [1:7] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low patterns for decimal digits 0..9.
  localparam seg_t SEG_TABLE [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  // True when the scan parameters describe a buildable driver.
  function automatic bit sevseg_params_ok(int digits, int scan_div, int blank_cycles);
    return (digits >= 1) && (digits <= 8) && (scan_div >= 2) &&
           (blank_cycles >= 0) && (blank_cycles < scan_div);
  endfunction

endpackage

// File: rtl/sevseg_scan_driver_if.sv
// Bundle between the score logic (master) and the scan driver (slave).
// Latency: n/a (wires only).
// Backpressure: none; load is a fire-and-forget strobe, display pins free-run.
interface sevseg_scan_driver_if #(parameter int DIGITS = 4);
  import sevseg_pkg::*;

  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_mask;
  seg_t                seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   an_n;
  logic                frame_done;

  modport master (
    output value, load, dp_in, blank_mask,
    input  seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  value, load, dp_in, blank_mask,
    output seg_n, dp_n, an_n, frame_done
  );

endinterface

// File: rtl/sevseg_scan_driver_digit_decoder.sv
// BCD nibble to active-low a..g pattern; 10..15 decode to all segments off.
// Latency: combinational.
// Backpressure: none.
module sevseg_digit_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  // Table lookup with dark as the default for non-decimal nibbles.
  always_comb begin
    seg = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (nib == 4'(i)) seg = SEG_TABLE[i];
    end
  end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Scans a shadowed multi-digit BCD value across common-anode digits, one digit per slot.
// Latency: outputs registered, 1 cycle after the cnt/idx/shadow state they reflect.
// Backpressure: none; loads are staged and take effect at the next slot boundary.
// Optional: define SEVSEG_LZB_EN for leading-zero blanking.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic reset,
  sevseg_scan_driver_if.slave bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  if (!sevseg_params_ok(DIGITS, SCAN_DIV, BLANK_CYCLES)) begin : g_bad_params
    $error("sevseg_scan_driver: illegal DIGITS/SCAN_DIV/BLANK_CYCLES");
  end

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                wrap;
  logic [4*DIGITS-1:0] sh_val, pd_val;
  logic [DIGITS-1:0]   sh_dp, pd_dp;
  logic [DIGITS-1:0]   sh_mask, pd_mask;
  logic                pend;
  logic [DIGITS-1:0]   lzb_dark;
  logic [3:0]          nib;
  seg_t                dec_seg;
  logic                dark;

  assign wrap = (cnt == CNT_LAST);

  // Slot prescaler and digit index; the index steps when the prescaler wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Loads stage into the pending set and commit only at a slot boundary so a
  // digit never changes mid-slot; a load on the boundary itself commits directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_val  <= '0;
      sh_dp   <= '0;
      sh_mask <= '0;
      pd_val  <= '0;
      pd_dp   <= '0;
      pd_mask <= '0;
      pend    <= 1'b0;
    end else if (wrap) begin
      pend <= 1'b0;
      if (bus.load) begin
        sh_val  <= bus.value;
        sh_dp   <= bus.dp_in;
        sh_mask <= bus.blank_mask;
      end else if (pend) begin
        sh_val  <= pd_val;
        sh_dp   <= pd_dp;
        sh_mask <= pd_mask;
      end
    end else if (bus.load) begin
      pd_val  <= bus.value;
      pd_dp   <= bus.dp_in;
      pd_mask <= bus.blank_mask;
      pend    <= 1'b1;
    end
  end

`ifdef SEVSEG_LZB_EN
  // Walk down from the top digit; the run of dark zeros ends at the first
  // nonzero digit or the first digit carrying a decimal point. Digit 0 always shows.
  always_comb begin
    logic run;
    run      = 1'b1;
    lzb_dark = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && (sh_val[4*i +: 4] == 4'd0) && !sh_dp[i]) lzb_dark[i] = 1'b1;
      else run = 1'b0;
    end
  end
`else
  assign lzb_dark = '0;
`endif

  assign nib  = sh_val[{idx, 2'b00} +: 4];
  assign dark = sh_mask[idx] | lzb_dark[idx];

  sevseg_digit_decoder u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // Register the pins; anodes stay off for the blanking window to avoid ghosting.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.an_n       <= '1;
      bus.seg_n      <= SEG_BLANK;
      bus.dp_n       <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.an_n       <= (cnt < BLANK_END) ? '1 : ~(DIGITS'(1) << idx);
      bus.seg_n      <= dark ? SEG_BLANK : dec_seg;
      bus.dp_n       <= dark | ~sh_dp[idx];
      bus.frame_done <= wrap && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed bench for sevseg_scan_driver with a per-cycle expected-output scoreboard.
module tb_sevseg_scan_driver;
  import sevseg_pkg::*;

  localparam seg_t D0 = 7'b0000001;
  localparam seg_t D1 = 7'b1001111;
  localparam seg_t D2 = 7'b0010010;
  localparam seg_t D4 = 7'b1001100;
  localparam seg_t D5 = 7'b0100100;
  localparam seg_t D7 = 7'b0001111;
  localparam seg_t D8 = 7'b0000000;
  localparam seg_t D9 = 7'b0000100;
  localparam seg_t DK = 7'b1111111;

  typedef struct packed {
    seg_t       seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  logic clk;
  logic reset;
  sevseg_scan_driver_if #(.DIGITS(4)) bus ();

  sevseg_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  logic [3:0] AN_TAB [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  // Reference state: position in the scan plus displayed and pending fields.
  int          m_cnt = 0, m_idx = 0;
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_dp = '0, m_mask = '0, p_dp = '0, p_mask = '0;
  logic        m_pend = 1'b0;

  seg_t       o_seg;
  logic       o_dp, o_fd;
  logic [3:0] o_an;
  int         nfd;

  function automatic seg_t ref_dec(logic [3:0] n);
    case (n)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic ref_dark(int i);
    logic dk;
    dk = m_mask[i];
`ifdef SEVSEG_LZB_EN
    if (i != 0) begin
      logic all_zero;
      all_zero = 1'b1;
      for (int j = 3; j >= i; j--) begin
        if (m_val[j*4 +: 4] != 4'd0 || m_dp[j]) all_zero = 1'b0;
      end
      dk = dk | all_zero;
    end
`endif
    return dk;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: push the expected pins for this edge, advance the model,
  // then pop and compare against what the DUT shows after the edge.
  task automatic tick(output seg_t s, output logic d, output logic [3:0] a, output logic f);
    exp_t e;
    logic dk;
    logic wrap;
    if (reset) begin
      e.seg = 7'b1111111; e.dp = 1'b1; e.an = 4'hF; e.fd = 1'b0;
    end else begin
      dk    = ref_dark(m_idx);
      e.an  = (m_cnt < 2) ? 4'hF : ~(4'b0001 << m_idx);
      e.seg = dk ? 7'b1111111 : ref_dec(m_val[m_idx*4 +: 4]);
      e.dp  = dk | ~m_dp[m_idx];
      e.fd  = (m_idx == 3) && (m_cnt == 7);
    end
    sb.push_back(e);
    if (reset) begin
      m_cnt = 0; m_idx = 0; m_val = '0; m_dp = '0; m_mask = '0;
      p_val = '0; p_dp = '0; p_mask = '0; m_pend = 1'b0;
    end else begin
      wrap = (m_cnt == 7);
      if (wrap) begin
        if (bus.load) begin
          m_val = bus.value; m_dp = bus.dp_in; m_mask = bus.blank_mask;
        end else if (m_pend) begin
          m_val = p_val; m_dp = p_dp; m_mask = p_mask;
        end
        m_pend = 1'b0;
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        if (bus.load) begin
          p_val = bus.value; p_dp = bus.dp_in; p_mask = bus.blank_mask; m_pend = 1'b1;
        end
        m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("sb_seg", 32'(bus.seg_n), 32'(e.seg));
    check("sb_dp", 32'(bus.dp_n), 32'(e.dp));
    check("sb_an", 32'(bus.an_n), 32'(e.an));
    check("sb_fd", 32'(bus.frame_done), 32'(e.fd));
    s = bus.seg_n; d = bus.dp_n; a = bus.an_n; f = bus.frame_done;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(o_seg, o_dp, o_an, o_fd);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] mask);
    bus.value = v; bus.dp_in = dp; bus.blank_mask = mask; bus.load = 1'b1;
    tick(o_seg, o_dp, o_an, o_fd);
    bus.load = 1'b0; bus.dp_in = '0; bus.blank_mask = '0;
  endtask

  // One full slot of digit d starting at cnt=0, with literal expectations.
  task automatic run_slot(input string tag, input int d, input seg_t e_seg, input logic e_dp);
    seg_t s; logic dp; logic [3:0] a; logic f;
    for (int c = 0; c < 8; c++) begin
      tick(s, dp, a, f);
      if (c == 1) check({tag, "_blank_an"}, 32'(a), 32'hF);
      if (c == 4) begin
        check({tag, "_an"}, 32'(a), 32'(AN_TAB[d]));
        check({tag, "_seg"}, 32'(s), 32'(e_seg));
        check({tag, "_dp"}, 32'(dp), 32'(e_dp));
      end
      if (c == 7) check({tag, "_fd"}, 32'(f), 32'(d == 3));
    end
  endtask

  task automatic run_frame(input string tag, input int start, input seg_t e0, input seg_t e1,
                           input seg_t e2, input seg_t e3, input logic [3:0] edp);
    seg_t ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int k = 0; k < 4; k++) begin
      int d;
      d = (start + k) % 4;
      run_slot($sformatf("%s_d%0d", tag, d), d, ex[d], edp[d]);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.value = '0; bus.load = 1'b0; bus.dp_in = '0; bus.blank_mask = '0;

    // Reset state.
    tick(o_seg, o_dp, o_an, o_fd);
    check("rst_an", 32'(o_an), 32'hF);
    check("rst_seg", 32'(o_seg), 32'(DK));
    check("rst_dp", 32'(o_dp), 32'h1);
    check("rst_fd", 32'(o_fd), 32'h0);
    ticks(1);
    reset = 1'b0;

    // Free-running frame with all-zero shadow.
    nfd = 0;
    for (int j = 0; j < 32; j++) begin
      tick(o_seg, o_dp, o_an, o_fd);
      nfd += int'(o_fd);
      if (j % 8 < 2) check("p1_an_blank", 32'(o_an), 32'hF);
      else check("p1_an", 32'(o_an), 32'(AN_TAB[j/8]));
`ifdef SEVSEG_LZB_EN
      check("p1_seg", 32'(o_seg), 32'((j / 8 == 0) ? D0 : DK));
`else
      check("p1_seg", 32'(o_seg), 32'(D0));
`endif
      if (j == 31) check("p1_fd_last", 32'(o_fd), 32'h1);
    end
    check("p1_fd_count", 32'(nfd), 32'd1);

    // Mid-slot load is deferred to the next slot.
    ticks(3);
    bus.value = 16'h1905; bus.load = 1'b1;
    tick(o_seg, o_dp, o_an, o_fd);
    bus.load = 1'b0;
    check("p2_hold_load", 32'(o_seg), 32'(D0));
    for (int j = 0; j < 4; j++) begin
      tick(o_seg, o_dp, o_an, o_fd);
      check("p2_hold", 32'(o_seg), 32'(D0));
    end
    run_frame("p2", 1, D5, D0, D9, D1, 4'hF);

    // Leading zeros.
    do_load(16'h0040, 4'h0, 4'h0);
    ticks(7);
`ifdef SEVSEG_LZB_EN
    run_frame("p3", 2, D0, D4, DK, DK, 4'hF);
`else
    run_frame("p3", 2, D0, D4, D0, D0, 4'hF);
`endif
    do_load(16'h0000, 4'h0, 4'h0);
    ticks(7);
`ifdef SEVSEG_LZB_EN
    run_frame("p3z", 3, D0, DK, DK, DK, 4'hF);
`else
    run_frame("p3z", 3, D0, D0, D0, D0, 4'hF);
`endif

    // Non-decimal nibble, masked digit, decimal point on digit 0.
    do_load(16'h85C7, 4'b0001, 4'b0100);
    ticks(7);
    run_frame("p4", 0, D7, DK, DK, D8, 4'b1110);

    // Last load in a slot wins.
    ticks(1);
    do_load(16'h1111, 4'h0, 4'h0);
    ticks(1);
    do_load(16'h2222, 4'h0, 4'h0);
    ticks(4);
    run_frame("p5", 1, D2, D2, D2, D2, 4'hF);

    // Load on the boundary cycle shows in the very next slot.
    ticks(7);
    do_load(16'h4444, 4'h0, 4'h0);
    run_slot("p5b", 2, D4, 1'b1);

    // Reset mid-frame discards a pending load.
    ticks(2);
    do_load(16'h9999, 4'hF, 4'h0);
    ticks(1);
    reset = 1'b1;
    tick(o_seg, o_dp, o_an, o_fd);
    reset = 1'b0;
    check("p6_rst_an", 32'(o_an), 32'hF);
    check("p6_rst_seg", 32'(o_seg), 32'(DK));
    check("p6_rst_dp", 32'(o_dp), 32'h1);
`ifdef SEVSEG_LZB_EN
    run_frame("p6", 0, D0, DK, DK, DK, 4'hF);
`else
    run_frame("p6", 0, D0, D0, D0, D0, 4'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_driver.md
# sevseg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. It holds a multi-digit BCD value in a shadow register and scans one digit per slot, driving shared active-low segment lines and one active-low digit enable per digit. A blanking interval at the start of each slot prevents ghosting. It sits between the game/score logic and the board display pins and supersedes the single-digit combinational decode path.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, default 500: cycles at the start of each slot with all digits disabled; must be < `SCAN_DIV`.
- `clk` in 1: system clock; all state is updated on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `value` in 4*DIGITS: BCD nibbles; digit 0 (rightmost) is `[3:0]`.
- `load` in 1: one-cycle strobe; captures `value`, `dp_in`, `blank_mask`.
- `dp_in` in DIGITS: decimal point request per digit, active-high.
- `blank_mask` in DIGITS: forces the digit dark, active-high.
- `seg_n` out 7: segments a..g, index 1 = a … 7 = g, active-low.
- `dp_n` out 1: decimal point, active-low.
- `an_n` out DIGITS: digit enables, active-low, at most one low.
- `frame_done` out 1: one-cycle pulse per completed scan frame.

## Operation
- Prescaler `cnt` counts 0..SCAN_DIV-1 and wraps. Digit index `idx` advances (mod DIGITS) when `cnt` wraps.
- `load`: captured fields go to a pending register and set `pend`. At the slot boundary (`cnt` wrap), the shadow takes the pending fields and `pend` clears. `load` on the boundary cycle writes the shadow directly. A second `load` before the boundary overwrites pending; the last load wins.
- Decode, active-low a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Nibbles 10–15 decode to 1111111 (dark).
- The selected digit is dark (`seg_n`=1111111, `dp_n`=1) if it is masked, or blanked by LZB (see Configuration). `an_n` still enables a dark digit.
- During `cnt` < BLANK_CYCLES, `an_n` is all ones. Otherwise `an_n[idx]`=0.
- `frame_done` goes high for the cycle in which `idx`=DIGITS-1 and `cnt`=SCAN_DIV-1 (registered).

## Timing
- All outputs are registered, with 1-cycle latency from `cnt`/`idx`/shadow state.
- Reset values: `cnt`=0, `idx`=0, shadow and pending all 0, `pend`=0, `an_n` all ones, `seg_n`=1111111, `dp_n`=1, `frame_done`=0.
- After `reset` deasserts, the first slot (digit 0) starts at `cnt`=0. `an_n[0]` falls at output cycle BLANK_CYCLES+1.
- Slot length is SCAN_DIV cycles. Frame length is DIGITS×SCAN_DIV cycles.
- `reset` mid-slot returns to the reset state on the next edge; a pending load is discarded.
- DIGITS=1: `idx` stays 0, and `frame_done` pulses once per slot.

## Configuration
- `SEVSEG_LZB_EN` defined: leading-zero blanking is on. Counting from the most significant digit downward, consecutive zero digits are dark. Digit 0 is never blanked by LZB. A digit with `dp_in` set stops the blanking run and is shown.
- `SEVSEG_LZB_EN` undefined: all unmasked digits are displayed, zeros included.

## Structure
- Package `sevseg_pkg` holds the segment constants (`SEG_BLANK`=7'b1111111, a 0–9 pattern table), the `seg_t` typedef (logic [1:7]), and parameter legality checks.
- Sub-module `sevseg_digit_decoder`: combinational nibble→`seg_t`, dark for 10–15, instantiated once on the selected nibble.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
- Reset, then run 32 cycles with no load → `an_n` sequence E,D,B,7 (each low for 6 cycles after 2 all-ones cycles), `seg_n`=0000001 throughout (LZB undefined), `frame_done` at cycle 32.
- Load `value`=16'h1905 at `cnt`=3 of slot 0 → slot 0 continues showing 0. From the next slot: digit1=0000001, digit2=0000100, digit3=1001111, digit0=0100100.
- `SEVSEG_LZB_EN` defined, load 16'h0040 → digits 3 and 2 dark with `an_n` still cycling, digit1=1001100, digit0=0000001. Load 16'h0000 → only digit0 lit.
- Load a nibble of 4'hC and set `blank_mask`=4'b0100 → the 4'hC digit reads 1111111, digit 2 is dark, and `dp_in`=4'b0001 drives `dp_n`=0 only in digit 0's slot.
- Two loads (16'h1111, then 16'h2222) in the same slot → only 16'h2222 is ever displayed. A load on the boundary cycle shows in the very next slot.
- Assert `reset` mid-frame with a pending load → `an_n` all ones and `seg_n`=1111111 next cycle, then a restart from digit 0 showing zeros.
